// File: rtl/canny_pkg.sv
// Shared definitions for the Canny pipeline stages: packed pixel layout and
// quantised gradient direction codes.
package canny_pkg;

  localparam int unsigned GRAD_WIDTH = 24;
  localparam int unsigned DIR_WIDTH  = 2;
  localparam int unsigned DATA_WIDTH = GRAD_WIDTH + DIR_WIDTH;

  // Packed pixel is {dir, grad}; grad occupies the low bits.
  localparam int unsigned GRAD_LSB = 0;
  localparam int unsigned DIR_LSB  = GRAD_WIDTH;

  localparam logic [DIR_WIDTH-1:0] DIR_H   = 2'b00;
  localparam logic [DIR_WIDTH-1:0] DIR_45  = 2'b01;
  localparam logic [DIR_WIDTH-1:0] DIR_V   = 2'b10;
  localparam logic [DIR_WIDTH-1:0] DIR_135 = 2'b11;

endpackage

// File: rtl/canny_pix_counter.sv
// Window-centre column/row tracker shared by the Canny post-gradient stages.
// border/last are registered and describe the stored (col,row) position.
module canny_pix_counter #(
  parameter int unsigned WIDTH = 636,
  parameter int unsigned DEPTH = 508
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     advance,
  output logic [$clog2(WIDTH)-1:0] col,
  output logic [$clog2(DEPTH)-1:0] row,
  output logic                     border,
  output logic                     last
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(DEPTH);

  logic [CW-1:0] col_base, col_nx;
  logic [RW-1:0] row_base, row_nx;
  logic          border_nx, last_nx;

  // start rebases the count to (0,0) before any advance in the same cycle
  always_comb begin
    col_base = start ? '0 : col;
    row_base = start ? '0 : row;
    col_nx   = col_base;
    row_nx   = row_base;
    if (advance) begin
      if (col_base == CW'(WIDTH - 1)) begin
        col_nx = '0;
        row_nx = (row_base == RW'(DEPTH - 1)) ? '0 : row_base + RW'(1);
      end else begin
        col_nx = col_base + CW'(1);
      end
    end
    border_nx = (col_nx == '0) || (col_nx == CW'(WIDTH - 1)) ||
                (row_nx == '0) || (row_nx == RW'(DEPTH - 1));
    last_nx   = (col_nx == CW'(WIDTH - 1)) && (row_nx == RW'(DEPTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      border <= 1'b1;
      last   <= 1'((WIDTH == 1) && (DEPTH == 1));
    end else begin
      col    <= col_nx;
      row    <= row_nx;
      border <= border_nx;
      last   <= last_nx;
    end
  end

endmodule

// File: rtl/canny_nms_core.sv
// Canny non-maximum suppression: keeps the centre magnitude only when it is a
// local maximum along its gradient direction; two-stage pipeline, no stalls.
module canny_nms_core #(
  parameter int unsigned WIDTH      = 636,
  parameter int unsigned DEPTH      = 508,
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned GRAD_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  win_valid,
  input  logic [DATA_WIDTH-1:0] p11,
  input  logic [DATA_WIDTH-1:0] p12,
  input  logic [DATA_WIDTH-1:0] p13,
  input  logic [DATA_WIDTH-1:0] p21,
  input  logic [DATA_WIDTH-1:0] p22,
  input  logic [DATA_WIDTH-1:0] p23,
  input  logic [DATA_WIDTH-1:0] p31,
  input  logic [DATA_WIDTH-1:0] p32,
  input  logic [DATA_WIDTH-1:0] p33,
  output logic                  nms_valid,
  output logic [GRAD_WIDTH-1:0] nms_mag,
  output logic [1:0]            nms_dir,
  output logic                  frame_done
);
  import canny_pkg::*;

  localparam int unsigned CW          = $clog2(WIDTH);
  localparam int unsigned RW          = $clog2(DEPTH);
  localparam logic        ORIGIN_LAST = 1'((WIDTH == 1) && (DEPTH == 1));

  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          pos_border, pos_last;
  logic          unused_pos;

  canny_pix_counter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_pix_counter (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .advance (win_valid),
    .col     (pos_col),
    .row     (pos_row),
    .border  (pos_border),
    .last    (pos_last)
  );

  assign unused_pos = ^{pos_col, pos_row};

  logic [GRAD_WIDTH-1:0] c_mag, a_mag, b_mag;
  logic [1:0]            c_dir;

  // Neighbour pair along the quantised gradient direction
  always_comb begin
    c_mag = p22[GRAD_WIDTH-1:0];
    c_dir = p22[DATA_WIDTH-1:GRAD_WIDTH];
    a_mag = p21[GRAD_WIDTH-1:0];
    b_mag = p23[GRAD_WIDTH-1:0];
    case (c_dir)
      DIR_45: begin
        a_mag = p13[GRAD_WIDTH-1:0];
        b_mag = p31[GRAD_WIDTH-1:0];
      end
      DIR_V: begin
        a_mag = p12[GRAD_WIDTH-1:0];
        b_mag = p32[GRAD_WIDTH-1:0];
      end
      DIR_135: begin
        a_mag = p11[GRAD_WIDTH-1:0];
        b_mag = p33[GRAD_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  logic                  s1_valid, s1_border, s1_last;
  logic [GRAD_WIDTH-1:0] s1_c, s1_a, s1_b;
  logic [1:0]            s1_dir;

  // A window coinciding with start is pixel (0,0), always a border pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_last   <= 1'b0;
      s1_c      <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_dir    <= '0;
    end else begin
      s1_valid <= win_valid;
      if (win_valid) begin
        s1_border <= start | pos_border;
        s1_last   <= start ? ORIGIN_LAST : pos_last;
        s1_c      <= c_mag;
        s1_a      <= a_mag;
        s1_b      <= b_mag;
        s1_dir    <= c_dir;
      end
    end
  end

  logic keep;
  // Asymmetric tie rule: exactly one pixel of an equal pair survives
  assign keep = !s1_border && (s1_c >= s1_a) && (s1_c > s1_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nms_valid  <= 1'b0;
      nms_mag    <= '0;
      nms_dir    <= '0;
      frame_done <= 1'b0;
    end else begin
      nms_valid  <= s1_valid;
      nms_mag    <= (s1_valid && keep) ? s1_c : '0;
      nms_dir    <= s1_valid ? s1_dir : '0;
      frame_done <= s1_valid & s1_last;
    end
  end

endmodule

// File: tb/tb_canny_nms_core.sv
// Scoreboard bench for canny_nms_core on a small 8x6 frame with a
// position-tracking reference model.
module tb_canny_nms_core;

  localparam int W = 8;
  localparam int D = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        win_valid = 1'b0;
  logic [25:0] win [9];
  logic        nms_valid;
  logic [23:0] nms_mag;
  logic [1:0]  nms_dir;
  logic        frame_done;

  canny_nms_core #(
    .WIDTH      (W),
    .DEPTH      (D),
    .DATA_WIDTH (26),
    .GRAD_WIDTH (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .win_valid  (win_valid),
    .p11        (win[0]),
    .p12        (win[1]),
    .p13        (win[2]),
    .p21        (win[3]),
    .p22        (win[4]),
    .p23        (win[5]),
    .p31        (win[6]),
    .p32        (win[7]),
    .p33        (win[8]),
    .nms_valid  (nms_valid),
    .nms_mag    (nms_mag),
    .nms_dir    (nms_dir),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] mag;
    logic [1:0]  dir;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_valid = 0;
  int   n_done = 0;
  int   mcol = 0;
  int   mrow = 0;
  // Neighbour indices (row-major p11..p33) for each direction code
  int   nb_a[4] = '{3, 2, 1, 0};
  int   nb_b[4] = '{5, 6, 7, 8};

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position bookkeeping plus the suppression rule
  task automatic issue(input logic v, input logic s);
    exp_t        e;
    logic [1:0]  d;
    logic [23:0] c, a, b;
    bit          border;
    win_valid = v;
    start     = s;
    if (s) begin
      mcol = 0;
      mrow = 0;
    end
    if (v) begin
      border = (mcol == 0) || (mcol == W - 1) || (mrow == 0) || (mrow == D - 1);
      d = win[4][25:24];
      c = win[4][23:0];
      a = win[nb_a[d]][23:0];
      b = win[nb_b[d]][23:0];
      e.mag  = (!border && c >= a && c > b) ? c : 24'd0;
      e.dir  = d;
      e.last = (mrow == D - 1) && (mcol == W - 1);
      e.cyc  = cyc;
      sb.push_back(e);
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow == D - 1) ? 0 : mrow + 1;
      end
    end
    @(posedge clk);
    #1;
    win_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic rand_win();
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(0, 3) == 0)
        win[i] = {2'($urandom_range(0, 3)), 24'($urandom)};
      else
        win[i] = {2'($urandom_range(0, 3)), 24'($urandom_range(0, 7))};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0);
  endtask

  // Directed window at interior pixel (1,1) after a start
  task automatic interior(input logic [1:0] d, input int c,
                          input int ia, input int va, input int ib, input int vb);
    issue(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      rand_win();
      issue(1'b1, 1'b0);
    end
    for (int i = 0; i < 9; i++) win[i] = {2'b11, 24'd50};
    win[4]  = {d, 24'(c)};
    win[ia] = {2'b11, 24'(va)};
    win[ib] = {2'b11, 24'(vb)};
    issue(1'b1, 1'b0);
    idle(3);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (nms_valid) begin
        n_valid++;
        if (frame_done) n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("mag", nms_mag, e.mag);
          chk("dir", nms_dir, e.dir);
          chk("frame_done", frame_done, e.last);
          chk("latency", cyc - e.cyc, 2);
        end
      end else begin
        chk("idle_zero", {nms_mag, nms_dir, frame_done}, 0);
      end
    end
  end

  initial begin
    int snap_v, snap_d, pix;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) win[i] = '0;

    #1;
    chk("reset_valid", nms_valid, 0);
    chk("reset_mag", nms_mag, 0);
    chk("reset_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Constant window: every pixel is border or tie-suppressed
    issue(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) win[i] = {2'b00, 24'h10};
    snap_d = n_done;
    for (int i = 0; i < 48; i++) issue(1'b1, 1'b0);
    idle(3);
    chk("const_frame_done", n_done - snap_d, 1);

    // Direction select and tie rule
    interior(2'b00, 100, 3, 50, 5, 120);
    interior(2'b01, 100, 1, 120, 6, 50);
    interior(2'b10, 100, 1, 50, 7, 120);
    interior(2'b11, 100, 2, 120, 8, 50);
    interior(2'b00, 80, 3, 80, 5, 79);
    interior(2'b00, 80, 3, 79, 5, 80);

    // Gapped input over a full frame
    issue(1'b0, 1'b1);
    snap_v = n_valid;
    snap_d = n_done;
    pix = 0;
    for (int k = 0; pix < 48; k++) begin
      if (pat[k % 4]) begin
        rand_win();
        issue(1'b1, 1'b0);
        pix++;
      end else begin
        issue(1'b0, 1'b0);
      end
    end
    idle(3);
    chk("gap_valid_count", n_valid - snap_v, 48);
    chk("gap_done_count", n_done - snap_d, 1);

    // Random frames running past the end without start (overrun wraps)
    issue(1'b0, 1'b1);
    for (int i = 0; i < 110; i++) begin
      rand_win();
      issue(1'($urandom_range(0, 3) != 0), 1'b0);
    end
    idle(3);

    // start coincident with a window mid-frame
    issue(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      rand_win();
      issue(1'b1, 1'b0);
    end
    rand_win();
    snap_d = n_done;
    issue(1'b1, 1'b1);
    for (int i = 0; i < 46; i++) begin
      rand_win();
      issue(1'b1, 1'b0);
    end
    idle(3);
    chk("restart_no_early_done", n_done - snap_d, 0);
    rand_win();
    issue(1'b1, 1'b0);
    idle(3);
    chk("restart_done", n_done - snap_d, 1);

    // Asynchronous reset with two pixels in flight
    issue(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      rand_win();
      issue(1'b1, 1'b0);
    end
    #1 rst = 1'b1;
    sb.delete();
    mcol = 0;
    mrow = 0;
    #1;
    chk("async_rst_valid", nms_valid, 0);
    chk("async_rst_mag", nms_mag, 0);
    chk("async_rst_dir", nms_dir, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    snap_v = n_valid;
    idle(2);
    chk("post_rst_quiet", n_valid - snap_v, 0);

    // Short random run after reset
    issue(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      rand_win();
      issue(1'b1, 1'b0);
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
